dt_bitmap_packer: RTL

Post-processing block for the distance-transform design. It reads the finished 128x128 8-bit result image from the res RAM and thresholds each pixel to one bit. It packs 16 consecutive pixels per 16-bit word and writes the 1024-word bitmap out in the same format the sti ROM uses, so a DT result can be re-fed or compared as a binary image. It is the reverse of DT's unpack/initialise phase: 8-bit pixels in, 16-bit packed words out.

---
 rtl/dt_bitmap_packer_if.sv | 29 ++
 rtl/dt_bitmap_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dt_bitmap_packer_if.sv
// Bus bundle between the bitmap packer and its surroundings.
// The packer drives the master side. The res RAM, the packed-bitmap sink and the controller drive the slave side.
interface dt_bitmap_packer_if;
  // Handshake semantics. There is no back-pressure anywhere on this bus.
  //  - start is a request. It is sampled only while the packer is idle or done, and ignored while busy.
  //  - res_rd/res_addr present one pixel read. res_di must carry that pixel during the following cycle.
  //  - pk_wr is a single-cycle write strobe that qualifies pk_addr/pk_do. The sink accepts it unconditionally.
  //  - busy/done/fg_count are status levels.
  logic        start;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic [14:0] fg_count;

  modport master (
    input  start, res_di,
    output busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_count
  );

  modport slave (
    output start, res_di,
    input  busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_count
  );
endinterface

// File: rtl/dt_bitmap_packer.sv
// Reads the 128x128 8-bit DT result image and thresholds every pixel to one bit.
// Sixteen consecutive pixels are packed per word, column 0 in the MSB.
// The result is 1024 16-bit words in the same layout as the sti ROM.
// Each word takes 18 cycles:
//  - 16 read cycles,
//  - 1 cycle to catch the last read datum,
//  - 1 write cycle.
module dt_bitmap_packer #(
  parameter logic [7:0] THRESH = 8'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  dt_bitmap_packer_if.master    bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  w_q, w_d;        // word index {row, col[6:4]}
  logic [3:0]  c_q, c_d;        // pixel index currently on res_addr
  logic [15:0] sh_q, sh_d;      // word under assembly, MSB = column 0
  logic [14:0] fg_q, fg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_q, rd_d;
  logic [13:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [9:0]  paddr_q, paddr_d;
  logic [15:0] pdo_q, pdo_d;

  logic        pix_bit;
  logic [15:0] word_full;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Data on res_di belongs to the address strobed one cycle earlier.
  assign pix_bit   = (bus.res_di > THRESH);
  assign word_full = {sh_q[14:0], pix_bit};

  // Next-state and next-output logic. Every output is registered from these *_d values.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    c_d     = c_q;
    sh_d    = sh_q;
    fg_d    = fg_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    paddr_d = paddr_q;
    pdo_d   = pdo_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          w_d     = 10'd0;
          c_d     = 4'd0;
          sh_d    = 16'd0;
          fg_d    = 15'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          rd_d    = 1'b1;
          addr_d  = 14'd0;
          state_d = READ;
        end
      end

      READ: begin
        // Pixel c-1 is on res_di now. At c = 0 nothing useful has returned yet.
        if (c_q != 4'd0) begin
          sh_d = word_full;
        end
        if (c_q == 4'd15) begin
          state_d = LAST;
        end else begin
          c_d    = c_q + 4'd1;
          rd_d   = 1'b1;
          addr_d = {w_q, c_q + 4'd1};
        end
      end

      LAST: begin
        // The 16th pixel arrives here. Issue the write and account for the word together.
        sh_d    = word_full;
        wr_d    = 1'b1;
        paddr_d = w_q;
        pdo_d   = word_full;
        fg_d    = fg_q + {10'd0, popcount16(word_full)};
        state_d = WRITE;
      end

      WRITE: begin
        if (w_q == 10'd1023) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          w_d     = w_q + 10'd1;
          c_d     = 4'd0;
          rd_d    = 1'b1;
          addr_d  = {w_q + 10'd1, 4'd0};
          state_d = READ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, which discards a partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= 10'd0;
      c_q     <= 4'd0;
      sh_q    <= 16'd0;
      fg_q    <= 15'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 14'd0;
      wr_q    <= 1'b0;
      paddr_q <= 10'd0;
      pdo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      c_q     <= c_d;
      sh_q    <= sh_d;
      fg_q    <= fg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      paddr_q <= paddr_d;
      pdo_q   <= pdo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.res_rd   = rd_q;
  assign bus.res_addr = addr_q;
  assign bus.pk_wr    = wr_q;
  assign bus.pk_addr  = paddr_q;
  assign bus.pk_do    = pdo_q;
  assign bus.fg_count = fg_q;
  assign dbg_state    = state_q;

endmodule
